// File: rtl/bp_pkg.sv
// Shared constants for the fetch-side branch history table.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bp_pkg;

    // 2-bit direction counter encodings; bit 1 is the predicted direction.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Counter value after reset, and value given to a freshly allocated entry.
    localparam logic [1:0] CTR_RESET = WNT;
    localparam logic [1:0] CTR_ALLOC = WT;

    // Fall-through distance for a not-taken branch (32-bit instructions only).
    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/bp_sat_ctr.sv
// Two-bit saturating counter next-state function.
// Latency: combinational.
// Backpressure: none.
// Ports: ctr (current state), taken (resolved direction), ctr_next (new state).
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != ST) begin
                ctr_next = ctr + 2'd1;
            end
        end else begin
            if (ctr != SNT) begin
                ctr_next = ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table + target buffer; learns from EX, redirects on mispredict.
// Latency: prediction is combinational from fetch_pc; redirect is registered, 1 cycle after EX.
// Backpressure: none; one EX update accepted every cycle, redirect is a fire-and-forget pulse.
// Ports: fetch_pc -> pred_taken/pred_target; ex_* resolution inputs -> table update,
//        redirect_valid/redirect_pc, br_count/mp_count (saturating statistics).
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_taken,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     br_count,
    output logic [31:0]     mp_count
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;

    // Table storage; targets are word aligned so the low two bits are dropped.
    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [1:0]        ctr_q   [ENTRIES];
    logic [XLEN-3:0]   tgt_q   [ENTRIES];

    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic [31:0]       br_count_q, br_count_d;
    logic [31:0]       mp_count_q, mp_count_d;

    // ---------------- fetch-side read ----------------
    logic [IDX_BITS-1:0] f_idx;
    logic [TAG_W-1:0]    f_tag;
    logic                f_hit;
    logic                unused_fetch_bits;

    assign f_idx = fetch_pc[IDX_BITS+1:2];
    assign f_tag = fetch_pc[XLEN-1:IDX_BITS+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign unused_fetch_bits = ^fetch_pc[1:0];

    // Reads the registered table, so a same-cycle update is only seen next cycle.
    assign pred_taken  = f_hit && ctr_q[f_idx][1];
    assign pred_target = {tgt_q[f_idx], 2'b00};

    // ---------------- EX-side update ----------------
    logic [IDX_BITS-1:0] e_idx;
    logic [TAG_W-1:0]    e_tag;
    logic                e_hit;
    logic                upd;
    logic                mispredict;
    logic [1:0]          ctr_next;

    assign e_idx = ex_pc[IDX_BITS+1:2];
    assign e_tag = ex_pc[XLEN-1:IDX_BITS+2];
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign upd   = ex_valid && ex_is_branch;

    bp_sat_ctr u_sat_ctr (
        .ctr      (ctr_q[e_idx]),
        .taken    (ex_taken),
        .ctr_next (ctr_next)
    );

    always_comb begin
        // A wrong target only matters when both the guess and the outcome are taken.
        mispredict = upd && ((ex_pred_taken != ex_taken) ||
                             (ex_taken && ex_pred_taken && (ex_pred_target != ex_target)));

        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        if (mispredict) begin
            redirect_pc_d = ex_taken ? ex_target : ex_pc + XLEN'(PC_STEP);
        end

        br_count_d = br_count_q;
        if (upd && (br_count_q != 32'hFFFF_FFFF)) begin
            br_count_d = br_count_q + 32'd1;
        end

        mp_count_d = mp_count_q;
        if (mispredict && (mp_count_q != 32'hFFFF_FFFF)) begin
            mp_count_d = mp_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= CTR_RESET;
                tgt_q[i]   <= '0;
            end
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_count_q       <= '0;
            mp_count_q       <= '0;
        end else begin
            if (upd) begin
                if (e_hit) begin
                    ctr_q[e_idx] <= ctr_next;
                    if (ex_taken) begin
                        tgt_q[e_idx] <= ex_target[XLEN-1:2];
                    end
                end else if (ex_taken) begin
                    // Allocate (or steal an aliased slot) only for taken branches.
                    valid_q[e_idx] <= 1'b1;
                    tag_q[e_idx]   <= e_tag;
                    tgt_q[e_idx]   <= ex_target[XLEN-1:2];
                    ctr_q[e_idx]   <= CTR_ALLOC;
                end
            end
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            br_count_q       <= br_count_d;
            mp_count_q       <= mp_count_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign br_count       = br_count_q;
    assign mp_count       = mp_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

    localparam int IDX_BITS = 6;
    localparam int XLEN     = 32;
    localparam int ENTRIES  = 1 << IDX_BITS;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] fetch_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic            ex_is_branch;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_taken;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     br_count;
    logic [31:0]     mp_count;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor_bht #(.IDX_BITS(IDX_BITS), .XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_taken       (ex_taken),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .br_count       (br_count),
        .mp_count       (mp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] fetch;
        logic        v;
        logic        br;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
        logic        ptk;
        logic [31:0] ptgt;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic [31:0] e_br;
        logic [31:0] e_mp;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [31:0] fetch, input logic v, input logic br,
                                input logic [31:0] pc, input logic [31:0] tgt,
                                input logic tk, input logic ptk, input logic [31:0] ptgt,
                                input logic e_rv, input logic [31:0] e_rpc,
                                input logic e_pt, input logic [31:0] e_ptgt,
                                input logic [31:0] e_br, input logic [31:0] e_mp);
        vec_t r;
        r.fetch = fetch; r.v = v; r.br = br; r.pc = pc; r.tgt = tgt;
        r.tk = tk; r.ptk = ptk; r.ptgt = ptgt;
        r.e_rv = e_rv; r.e_rpc = e_rpc; r.e_pt = e_pt; r.e_ptgt = e_ptgt;
        r.e_br = e_br; r.e_mp = e_mp;
        return r;
    endfunction

    task automatic drive_ex(input logic v, input logic br, input logic [31:0] pc,
                            input logic [31:0] tgt, input logic tk, input logic ptk,
                            input logic [31:0] ptgt);
        ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_target = tgt;
        ex_taken = tk; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    // ---------------- behavioural reference model ----------------
    bit          m_valid [ENTRIES];
    logic [31:0] m_owner [ENTRIES];   // full PC that owns the slot
    int          m_str   [ENTRIES];   // confidence 0..3, taken when >= 2
    logic [31:0] m_tgt   [ENTRIES];
    int          m_br, m_mp;
    bit          m_rv;
    logic [31:0] m_rpc;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit same_tag(input logic [31:0] a, input logic [31:0] b);
        return (a / (4 * ENTRIES)) == (b / (4 * ENTRIES));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_owner[i] = 0; m_str[i] = 1; m_tgt[i] = 0;
        end
        m_br = 0; m_mp = 0; m_rv = 0; m_rpc = 0;
    endtask

    function automatic bit m_pred(input logic [31:0] pc);
        int s = slot(pc);
        return m_valid[s] && same_tag(m_owner[s], pc) && (m_str[s] >= 2);
    endfunction

    task automatic m_step(input logic v, input logic br, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic tk, input logic ptk,
                          input logic [31:0] ptgt);
        int s = slot(pc);
        bit hit = m_valid[s] && same_tag(m_owner[s], pc);
        bit wrong;
        m_rv = 0;
        if (v && br) begin
            wrong = (ptk != tk) || (tk && ptk && (ptgt != tgt));
            if (hit) begin
                if (tk) begin
                    m_str[s] = (m_str[s] + 1 > 3) ? 3 : m_str[s] + 1;
                    m_tgt[s] = tgt & ~32'd3;
                end else begin
                    m_str[s] = (m_str[s] - 1 < 0) ? 0 : m_str[s] - 1;
                end
            end else if (tk) begin
                m_valid[s] = 1; m_owner[s] = pc; m_tgt[s] = tgt & ~32'd3; m_str[s] = 2;
            end
            m_br++;
            if (wrong) begin
                m_mp++;
                m_rv = 1;
                m_rpc = tk ? tgt : pc + 32'd4;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_pc = 32'h100;
        drive_ex(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        //             fetch    v  br pc      tgt     tk ptk ptgt    rv rpc     pt ptgt    br mp
        vecs[0]  = mk(32'h100, 0, 0, 32'h0,   32'h0,  0, 0, 32'h0,  0, 32'h0,   0, 32'h0,  0, 0);
        vecs[1]  = mk(32'h100, 1, 1, 32'h100, 32'h80, 1, 0, 32'h0,  1, 32'h80,  1, 32'h80, 1, 1);
        vecs[2]  = mk(32'h100, 1, 1, 32'h100, 32'h80, 1, 1, 32'h80, 0, 32'h80,  1, 32'h80, 2, 1);
        vecs[3]  = mk(32'h100, 1, 1, 32'h100, 32'h80, 1, 1, 32'h80, 0, 32'h80,  1, 32'h80, 3, 1);
        vecs[4]  = mk(32'h100, 1, 1, 32'h100, 32'h80, 1, 1, 32'h80, 0, 32'h80,  1, 32'h80, 4, 1);
        vecs[5]  = mk(32'h100, 1, 1, 32'h100, 32'h80, 0, 1, 32'h80, 1, 32'h104, 1, 32'h80, 5, 2);
        vecs[6]  = mk(32'h100, 0, 1, 32'h100, 32'h40, 1, 0, 32'h0,  0, 32'h104, 1, 32'h80, 5, 2);
        vecs[7]  = mk(32'h100, 1, 1, 32'h200, 32'h200,1, 0, 32'h0,  1, 32'h200, 0, 32'h0,  6, 3);
        vecs[8]  = mk(32'h200, 0, 0, 32'h0,   32'h0,  0, 0, 32'h0,  0, 32'h200, 1, 32'h200,6, 3);
        vecs[9]  = mk(32'h200, 1, 1, 32'h200, 32'h90, 1, 1, 32'h80, 1, 32'h90,  1, 32'h90, 7, 4);
        vecs[10] = mk(32'h200, 1, 1, 32'h200, 32'h90, 0, 1, 32'h90, 1, 32'h204, 1, 32'h90, 8, 5);
        vecs[11] = mk(32'h200, 1, 1, 32'h300, 32'h400,0, 0, 32'h0,  0, 32'h204, 1, 32'h90, 9, 5);

        repeat (2) @(negedge clk);
        // Outputs while reset is held.
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        rst_n = 1'b1;

        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            fetch_pc = vecs[i].fetch;
            drive_ex(vecs[i].v, vecs[i].br, vecs[i].pc, vecs[i].tgt,
                     vecs[i].tk, vecs[i].ptk, vecs[i].ptgt);
            @(negedge clk);
            check($sformatf("v%0d_redirect_valid", i), {31'd0, redirect_valid}, {31'd0, vecs[i].e_rv});
            check($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
            check($sformatf("v%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
            if (vecs[i].e_pt) begin
                check($sformatf("v%0d_pred_target", i), pred_target, vecs[i].e_ptgt);
            end
            check($sformatf("v%0d_br_count", i), br_count, vecs[i].e_br);
            check($sformatf("v%0d_mp_count", i), mp_count, vecs[i].e_mp);
        end

        // Same-cycle fetch and update on one entry (0x200 is WT, target 0x90):
        // the fetch must see the old state until the edge, then the new one.
        fetch_pc = 32'h200;
        drive_ex(1'b1, 1'b1, 32'h200, 32'h90, 1'b0, 1'b1, 32'h90);
        #4;
        check("wr_pred_before_edge", {31'd0, pred_taken}, 32'd1);
        @(posedge clk);
        #1;
        drive_ex(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("wr_pred_after_edge", {31'd0, pred_taken}, 32'd0);
        check("wr_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("wr_redirect_pc", redirect_pc, 32'h204);

        // Reset in the middle of the redirect pulse.
        fetch_pc = 32'h100;
        drive_ex(1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("pre_rst_pred_taken", {31'd0, pred_taken}, 32'd1);
        check("pre_rst_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("mid_rst_redirect_pc", redirect_pc, 32'd0);
        check("mid_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("mid_rst_br_count", br_count, 32'd0);
        check("mid_rst_mp_count", mp_count, 32'd0);
        drive_ex(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- randomized phase against the model ----------------
        m_reset();
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc, tgt, fpc, ptgt;
            logic        v, br, tk, ptk;
            int          s, hi, fs, fhi;

            check("rnd_redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
            if (m_rv) check("rnd_redirect_pc", redirect_pc, m_rpc);
            check("rnd_br_count", br_count, m_br);
            check("rnd_mp_count", mp_count, m_mp);

            // Small set of slots and tags so hits, aliasing and PC wrap all occur.
            s  = $urandom_range(0, 8);   if (s == 8) s = 63;
            hi = $urandom_range(0, 3);
            pc = (hi == 3) ? (32'hFFFF_FF00 | (s << 2)) : ((hi << 8) | (s << 2));
            fs  = $urandom_range(0, 8);  if (fs == 8) fs = 63;
            fhi = $urandom_range(0, 3);
            fpc = (fhi == 3) ? (32'hFFFF_FF00 | (fs << 2)) : ((fhi << 8) | (fs << 2));
            tgt = $urandom & ~32'd3;
            if ($urandom_range(0, 1) == 1) tgt = 32'h1000 + ($urandom_range(0, 3) << 4);
            v   = ($urandom_range(0, 9) != 0);
            br  = ($urandom_range(0, 4) != 0);
            tk  = $urandom_range(0, 1);
            // Mostly carry the real prediction down the pipe, sometimes a stale one.
            if ($urandom_range(0, 3) != 0) begin
                ptk  = m_pred(pc);
                ptgt = m_tgt[slot(pc)];
            end else begin
                ptk  = $urandom_range(0, 1);
                ptgt = 32'h1000 + ($urandom_range(0, 3) << 4);
            end

            fetch_pc = fpc;
            drive_ex(v, br, pc, tgt, tk, ptk, ptgt);
            #1;
            check("rnd_pred_taken", {31'd0, pred_taken}, {31'd0, m_pred(fpc)});
            if (m_pred(fpc)) check("rnd_pred_target", pred_target, m_tgt[slot(fpc)]);
            @(posedge clk);
            m_step(v, br, pc, tgt, tk, ptk, ptgt);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
